// File: rtl/orpsoc_rst_seq.sv
// Board reset sequencer: synchronises pad reset release, holds all domains,
// then releases N_OUT reset domains in index order; supports soft restart.
module orpsoc_rst_seq #(
    parameter int N_OUT          = 3,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             sys_clk_pad_i,
    input  logic             rst_n_pad_i,
    input  logic             soft_rst_req_i,
    output logic [N_OUT-1:0] rst_o,
    output logic             rst_done_o,
    output logic [1:0]       rst_cause_o
);

    localparam int MAX_CNT = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAG_LAST = CW'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
    localparam bit ALL_AT_ONCE = (N_OUT == 1) || (STAGGER_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_DONE
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_sync_n;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             soft_q;
    logic             soft_prev_q;
    logic [N_OUT-1:0] rst_q;
    logic             done_q;
    logic [1:0]       cause_q;

    logic             soft_edge;
    logic [N_OUT-1:0] rst_next_d;

    // Asserts asynchronously, deasserts only after SYNC_STAGES clean edges.
    always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
        if (!rst_n_pad_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = sync_q[SYNC_STAGES-1];

    assign soft_edge = soft_q & ~soft_prev_q;
    // Released bits always form a contiguous low run, so one left shift frees the next domain.
    assign rst_next_d = rst_q << 1;

    always_ff @(posedge sys_clk_pad_i or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            soft_q      <= 1'b0;
            soft_prev_q <= 1'b0;
            rst_q       <= '1;
            done_q      <= 1'b0;
            cause_q     <= 2'b01;
        end else begin
            soft_q      <= soft_rst_req_i;
            soft_prev_q <= soft_q;
            if (soft_edge) begin
                state_q <= ST_HOLD;
                cnt_q   <= '0;
                rst_q   <= '1;
                done_q  <= 1'b0;
                cause_q <= 2'b10;
            end else begin
                case (state_q)
                    ST_HOLD: begin
                        if (cnt_q == HOLD_LAST) begin
                            cnt_q <= '0;
                            if (ALL_AT_ONCE) begin
                                rst_q   <= '0;
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                rst_q   <= rst_next_d;
                                state_q <= ST_RELEASE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_RELEASE: begin
                        if (cnt_q == STAG_LAST) begin
                            cnt_q <= '0;
                            rst_q <= rst_next_d;
                            if (rst_next_d == '0) begin
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        rst_q  <= '0;
                        done_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign rst_o       = rst_q;
    assign rst_done_o  = done_q;
    assign rst_cause_o = cause_q;

endmodule
